// File: rtl/covariance_serializer_pkg.sv
// rtl/covariance_serializer_pkg.sv - shared constants and helpers for the packed covariance upper triangle
package covariance_serializer_pkg;

    // Packed word k walks the upper triangle row by row:
    // (0,0)..(0,N-1), then (1,1)..(1,N-1), ... ending at (N-1,N-1).
    typedef enum logic {
        PACK_ROW_MAJOR_UPPER = 1'b0
    } packing_order_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Index tags never collapse to zero width, even for a 1x1 matrix.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : clog2(value);
    endfunction

    function automatic int n_outputs(input int n);
        return n * (n + 1) / 2;
    endfunction

endpackage

// File: rtl/covariance_serializer_triu_index_counter.sv
// rtl/covariance_serializer_triu_index_counter.sv - row/col/k walker over the packed upper triangle
module triu_index_counter
    import covariance_serializer_pkg::*;
#(
    parameter int N_INPUTS = 8,
    localparam int N_OUTPUTS = n_outputs(N_INPUTS),
    localparam int IDX_WIDTH = clog2_min1(N_INPUTS),
    localparam int K_WIDTH = clog2_min1(N_OUTPUTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 advance,
    output logic [IDX_WIDTH-1:0] row,
    output logic [IDX_WIDTH-1:0] col,
    output logic [K_WIDTH-1:0]   k,
    output logic                 last
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_INPUTS - 1);
    localparam logic [K_WIDTH-1:0]   LAST_K   = K_WIDTH'(N_OUTPUTS - 1);

    // load wins over advance so a back-to-back frame restarts at (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
            k   <= '0;
        end else if (load) begin
            row <= '0;
            col <= '0;
            k   <= '0;
        end else if (advance) begin
            k <= k + 1'b1;
            if (col == LAST_IDX) begin
                row <= row + 1'b1;
                col <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last = (k == LAST_K);

endmodule

// File: rtl/covariance_serializer.sv
// rtl/covariance_serializer.sv - captures a packed covariance triangle and streams it word by word
module covariance_serializer
    import covariance_serializer_pkg::*;
#(
    parameter int N_INPUTS = 8,
    parameter int DOUT_WIDTH = 32,
    parameter int DROP_CNT_WIDTH = 16,
    localparam int N_OUTPUTS = n_outputs(N_INPUTS),
    localparam int IDX_WIDTH = clog2_min1(N_INPUTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_OUTPUTS*DOUT_WIDTH-1:0] din,
    input  logic                            din_valid,
    output logic [DOUT_WIDTH-1:0]           dout,
    output logic [IDX_WIDTH-1:0]            dout_row,
    output logic [IDX_WIDTH-1:0]            dout_col,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic                            dout_last,
    output logic                            busy,
    output logic                            overflow,
    output logic [DROP_CNT_WIDTH-1:0]       drop_count,
    input  logic                            clear_overflow
);

    localparam int K_WIDTH = clog2_min1(N_OUTPUTS);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

    state_t                          state;
    state_t                          state_next;
    logic [N_OUTPUTS*DOUT_WIDTH-1:0] shadow;
    logic [K_WIDTH-1:0]              k;
    logic [IDX_WIDTH-1:0]            row;
    logic [IDX_WIDTH-1:0]            col;
    logic                            last;
    logic                            sending;
    logic                            xfer;
    logic                            last_xfer;
    logic                            capture;
    logic                            load;
    logic                            advance;
    logic                            drop;
    logic [DOUT_WIDTH-1:0]           word;

    assign sending   = (state == ST_SEND);
    assign xfer      = sending && dout_ready;
    assign last_xfer = xfer && last;
    assign drop      = sending && din_valid && !last_xfer;
    assign load      = capture || last_xfer;
    assign advance   = xfer && !last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (din_valid) begin
                    capture    = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (last_xfer) begin
                    if (din_valid) begin
                        capture = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Contents are meaningless until the first capture, so no reset is needed.
    always_ff @(posedge clk) begin
        if (capture) begin
            shadow <= din;
        end
    end

    triu_index_counter #(
        .N_INPUTS(N_INPUTS)
    ) u_index (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .advance(advance),
        .row    (row),
        .col    (col),
        .k      (k),
        .last   (last)
    );

    always_comb begin
        word = '0;
        for (int i = 0; i < N_OUTPUTS; i++) begin
            if (int'(k) == i) begin
                word = shadow[i*DOUT_WIDTH +: DOUT_WIDTH];
            end
        end
    end

    // The counter rests at (0,0) while idle, so the tags need no gating.
    assign dout_valid = sending;
    assign busy       = sending;
    assign dout       = sending ? word : '0;
    assign dout_row   = row;
    assign dout_col   = col;
    assign dout_last  = sending && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                drop_count <= DROP_CNT_WIDTH'(1);
            end else if (drop_count != DROP_MAX) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_covariance_serializer.sv
// tb/tb_covariance_serializer.sv - scoreboard bench for covariance_serializer with N_INPUTS=3
module tb_covariance_serializer;

    localparam int N    = 3;
    localparam int DW   = 32;
    localparam int NOUT = 6;
    localparam int IW   = 2;
    localparam int CW   = 2;

    logic              clk;
    logic              rst_n;
    logic [NOUT*DW-1:0] din;
    logic              din_valid;
    logic [DW-1:0]     dout;
    logic [IW-1:0]     dout_row;
    logic [IW-1:0]     dout_col;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic              busy;
    logic              overflow;
    logic [CW-1:0]     drop_count;
    logic              clear_overflow;

    covariance_serializer #(
        .N_INPUTS      (N),
        .DOUT_WIDTH    (DW),
        .DROP_CNT_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din           (din),
        .din_valid     (din_valid),
        .dout          (dout),
        .dout_row      (dout_row),
        .dout_col      (dout_col),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .dout_last     (dout_last),
        .busy          (busy),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .clear_overflow(clear_overflow)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            row;
        int            col;
        bit            last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   n_xfer     = 0;
    int   words_left = 0;
    bit   m_ovf      = 1'b0;
    int   m_drops    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a frame is accepted only when nothing is in flight or the
    // final word of the current frame leaves in the same cycle.
    task automatic model_step(input bit v, input logic [DW-1:0] base, input bit rdy, input bit clr);
        bit   xfer;
        bit   last_xfer;
        bit   accept;
        int   k;
        exp_t e;
        xfer      = (words_left > 0) && rdy;
        last_xfer = xfer && (words_left == 1);
        accept    = v && ((words_left == 0) || last_xfer);
        if (xfer) words_left--;
        if (accept) begin
            k = 0;
            for (int i = 0; i < N; i++) begin
                for (int j = i; j < N; j++) begin
                    e.data = base + DW'(k);
                    e.row  = i;
                    e.col  = j;
                    e.last = (i == N - 1) && (j == N - 1);
                    exp_q.push_back(e);
                    k++;
                end
            end
            words_left += NOUT;
        end
        if (v && !accept) begin
            m_ovf   = 1'b1;
            m_drops = clr ? 1 : ((m_drops == (1 << CW) - 1) ? m_drops : m_drops + 1);
        end else if (clr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
    endtask

    task automatic cycle(input bit v, input logic [DW-1:0] base, input bit rdy, input bit clr);
        din_valid      = v;
        dout_ready     = rdy;
        clear_overflow = clr;
        for (int k = 0; k < NOUT; k++) begin
            din[k*DW +: DW] = v ? base + DW'(k) : DW'($urandom());
        end
        @(posedge clk);
        model_step(v, base, rdy, clr);
        #1;
    endtask

    logic [DW+2*IW:0] held;
    bit               holding = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            holding = 1'b0;
        end else begin
            check("dout_valid", dout_valid, exp_q.size() > 0);
            check("busy", busy, exp_q.size() > 0);
            check("overflow", overflow, m_ovf);
            check("drop_count", drop_count, m_drops);
            if (holding) begin
                check("stall_stable", {dout, dout_row, dout_col, dout_last}, held);
            end
            if (dout_valid && exp_q.size() > 0) begin
                e = exp_q[0];
                check("dout", dout, e.data);
                check("dout_row", dout_row, e.row);
                check("dout_col", dout_col, e.col);
                check("dout_last", dout_last, e.last);
                if (dout_ready) begin
                    void'(exp_q.pop_front());
                    n_xfer++;
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held    = {dout, dout_row, dout_col, dout_last};
                end
            end else begin
                holding = 1'b0;
            end
        end
    end

    initial begin
        int start;
        rst_n          = 1'b0;
        din            = '0;
        din_valid      = 1'b0;
        dout_ready     = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout_valid", dout_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_dout_last", dout_last, 0);
        check("reset_dout", dout, 0);
        check("reset_row_col", {dout_row, dout_col}, 0);
        check("reset_overflow", overflow, 0);
        check("reset_drop_count", drop_count, 0);
        #2 rst_n = 1'b1;

        start = n_xfer;
        cycle(1, 32'h10, 1, 0);
        repeat (8) cycle(0, 0, 1, 0);
        check("basic_xfers", n_xfer - start, 6);

        start = n_xfer;
        cycle(1, 32'h10, 1, 0);
        for (int i = 0; i < 24; i++) cycle(0, 0, (i % 4 == 0) || (i % 4 == 3), 0);
        check("backpressure_xfers", n_xfer - start, 6);

        start = n_xfer;
        cycle(1, 32'h10, 1, 0);
        repeat (5) cycle(0, 0, 1, 0);
        cycle(1, 32'h20, 1, 0);
        repeat (8) cycle(0, 0, 1, 0);
        check("b2b_xfers", n_xfer - start, 12);
        check("b2b_overflow", overflow, 0);

        start = n_xfer;
        cycle(1, 32'h10, 1, 0);
        repeat (2) cycle(0, 0, 1, 0);
        cycle(1, 32'h30, 0, 0);
        repeat (8) cycle(0, 0, 1, 0);
        check("ovf_xfers", n_xfer - start, 6);
        check("ovf_flag", overflow, 1);
        check("ovf_count", drop_count, 1);
        cycle(0, 0, 1, 1);
        check("clear_flag", overflow, 0);
        check("clear_count", drop_count, 0);

        cycle(1, 32'h40, 0, 0);
        cycle(1, 32'h41, 0, 0);
        cycle(1, 32'h42, 0, 1);
        check("drop_beats_clear_flag", overflow, 1);
        check("drop_beats_clear_count", drop_count, 1);
        repeat (8) cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);

        cycle(1, 32'h70, 0, 0);
        repeat (5) cycle(1, $urandom(), 0, 0);
        check("saturate_count", drop_count, 3);
        repeat (8) cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);

        cycle(1, 32'h50, 1, 0);
        repeat (3) cycle(0, 0, 1, 0);
        check("pre_reset_word3", dout, 32'h53);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", dout_valid, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_last", dout_last, 0);
        exp_q.delete();
        words_left = 0;
        m_ovf      = 1'b0;
        m_drops    = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cycle(1, 32'h60, 1, 0);
        check("post_reset_word0", dout, 32'h60);
        check("post_reset_origin", {dout_row, dout_col}, 0);
        repeat (8) cycle(0, 0, 1, 0);

        repeat (400) cycle(($urandom() % 6) == 0, $urandom(), ($urandom() % 3) != 0, ($urandom() % 16) == 0);
        repeat (16) cycle(0, 0, 1, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
